iterative_divider: RTL and testbench

Multi-cycle restoring divider producing one quotient bit per clock by repeated trial subtraction. It is the inverse arithmetic counterpart to the combinational adder datapath and backs the M-extension DIV/DIVU/REM/REMU operations in the mini-CPU execute stage. Operands enter and results leave through valid/ready handshakes, so the stage can stall around the block's fixed multi-cycle latency.

---
 rtl/iterative_divider.sv | 184 ++++++++++++++++++
 tb/tb_iterative_divider.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/iterative_divider.sv
`default_nettype none
// ============================================================================
// Module      : iterative_divider
// Description : Restoring divider, one quotient bit per clock, valid/ready I/O.
//               Define SIGNED_DIV_EN to honour is_signed (RISC-V semantics).
// Revision    : 1.0 - initial release
// ============================================================================
module iterative_divider #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            is_signed,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder,
    output logic            div_by_zero
);

    localparam int CW = $clog2(XLEN + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [CW-1:0]   r_count;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_quo;
    logic [XLEN-1:0] r_dvsr;
    logic [XLEN-1:0] r_dividend;
    logic            r_dvsr_zero;
    logic [XLEN-1:0] r_quotient;
    logic [XLEN-1:0] r_remainder;
    logic            r_div_by_zero;

    logic            w_accept;
    logic [XLEN-1:0] w_dd_mag;
    logic [XLEN-1:0] w_dv_mag;
    logic [XLEN:0]   w_shifted;
    logic [XLEN:0]   w_trial;
    logic [XLEN-1:0] w_rem_next;
    logic [XLEN-1:0] w_quo_next;
    logic [XLEN-1:0] w_fix_q;
    logic [XLEN-1:0] w_fix_r;
    logic            w_fix_dbz;

`ifdef SIGNED_DIV_EN
    localparam logic [XLEN-1:0] C_MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
    logic w_dd_neg;
    logic w_dv_neg;
    logic w_ovf;
    logic r_q_neg;
    logic r_r_neg;
    logic r_ovf;

    assign w_dd_neg = is_signed & dividend[XLEN-1];
    assign w_dv_neg = is_signed & divisor[XLEN-1];
    assign w_dd_mag = w_dd_neg ? -dividend : dividend;
    assign w_dv_mag = w_dv_neg ? -divisor  : divisor;
    assign w_ovf    = is_signed && (dividend == C_MOST_NEG) && (divisor == '1);
`else
    logic w_unused;

    assign w_unused = is_signed;
    assign w_dd_mag = dividend;
    assign w_dv_mag = divisor;
`endif

    assign w_accept = (r_state == S_IDLE) && in_valid;

    // r_quo doubles as the dividend shift register: its MSB feeds the remainder
    // while freshly decided quotient bits enter at the LSB.
    assign w_shifted  = {r_rem, r_quo[XLEN-1]};
    assign w_trial    = w_shifted - {1'b0, r_dvsr};
    assign w_rem_next = w_trial[XLEN] ? w_shifted[XLEN-1:0] : w_trial[XLEN-1:0];
    assign w_quo_next = {r_quo[XLEN-2:0], ~w_trial[XLEN]};

    always_comb begin
        w_fix_q   = r_quo;
        w_fix_r   = r_rem;
        w_fix_dbz = 1'b0;
`ifdef SIGNED_DIV_EN
        if (r_q_neg) w_fix_q = -r_quo;
        if (r_r_neg) w_fix_r = -r_rem;
        if (r_ovf) begin
            w_fix_q = r_dividend;
            w_fix_r = '0;
        end
`endif
        if (r_dvsr_zero) begin
            w_fix_q   = '1;
            w_fix_r   = r_dividend;
            w_fix_dbz = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next_state = S_CALC;
            end
            S_CALC: if (r_count == CW'(1)) w_next_state = S_FIX;
            S_FIX:  w_next_state = S_DONE;
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count       <= '0;
            r_rem         <= '0;
            r_quo         <= '0;
            r_dvsr        <= '0;
            r_dividend    <= '0;
            r_dvsr_zero   <= 1'b0;
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
`ifdef SIGNED_DIV_EN
            r_q_neg       <= 1'b0;
            r_r_neg       <= 1'b0;
            r_ovf         <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_count     <= CW'(XLEN);
                        r_rem       <= '0;
                        r_quo       <= w_dd_mag;
                        r_dvsr      <= w_dv_mag;
                        r_dividend  <= dividend;
                        r_dvsr_zero <= (divisor == '0);
`ifdef SIGNED_DIV_EN
                        r_q_neg     <= w_dd_neg ^ w_dv_neg;
                        r_r_neg     <= w_dd_neg;
                        r_ovf       <= w_ovf;
`endif
                    end
                end
                S_CALC: begin
                    r_count <= r_count - 1'b1;
                    r_rem   <= w_rem_next;
                    r_quo   <= w_quo_next;
                end
                S_FIX: begin
                    r_quotient    <= w_fix_q;
                    r_remainder   <= w_fix_r;
                    r_div_by_zero <= w_fix_dbz;
                end
                default: ;
            endcase
        end
    end

    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_div_by_zero;

endmodule
`default_nettype wire

// File: tb/tb_iterative_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_iterative_divider
// Description : Self-checking bench for iterative_divider (directed + random).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iterative_divider;

    localparam int XLEN = 64;
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
`ifdef SIGNED_DIV_EN
    localparam bit SIGNED_MODE = 1'b1;
`else
    localparam bit SIGNED_MODE = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] dividend;
    logic [XLEN-1:0] divisor;
    logic            is_signed;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] quotient;
    logic [XLEN-1:0] remainder;
    logic            div_by_zero;

    iterative_divider #(.XLEN(XLEN)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .is_signed   (is_signed),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [XLEN-1:0] q;
        logic [XLEN-1:0] r;
        logic            dbz;
        int              acc;
    } exp_t;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;
    bit   seen     = 1'b0;
    exp_t exp_q[$];

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // RISC-V DIV/DIVU/REM/REMU semantics from plain arithmetic.
    function automatic exp_t ref_div(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input logic s);
        exp_t e;
        bit   sg;
        sg    = s & SIGNED_MODE;
        e.acc = 0;
        e.dbz = 1'b0;
        if (b == '0) begin
            e.q = '1; e.r = a; e.dbz = 1'b1;
        end else if (sg && a == MOST_NEG && b == '1) begin
            e.q = a; e.r = '0;
        end else if (sg) begin
            e.q = $signed(a) / $signed(b);
            e.r = $signed(a) % $signed(b);
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
        return e;
    endfunction

    // Accept/handshake monitor feeding the expectation queue.
    always @(posedge clk) begin
        exp_t e;
        cyc++;
        if (rst) begin
            exp_q.delete();
            seen = 1'b0;
        end else begin
            if (out_valid && out_ready && exp_q.size() > 0) begin
                exp_q.delete(0);
                seen = 1'b0;
            end
            if (in_valid && in_ready) begin
                e     = ref_div(dividend, divisor, is_signed);
                e.acc = cyc;
                exp_q.push_back(e);
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (!rst && exp_q.size() > 0) begin
            check("busy_in_ready", {63'd0, in_ready}, 64'd0);
            if (out_valid) begin
                check("quotient", quotient, exp_q[0].q);
                check("remainder", remainder, exp_q[0].r);
                check("div_by_zero", {63'd0, div_by_zero}, {63'd0, exp_q[0].dbz});
                if (!seen) begin
                    seen = 1'b1;
                    check("latency", 64'(cyc - exp_q[0].acc), 64'(XLEN + 1));
                end
            end else if (cyc - exp_q[0].acc == XLEN + 1) begin
                check("out_valid_at_latency", {63'd0, out_valid}, 64'd1);
            end
        end else if (!rst && out_valid) begin
            check("spurious_out_valid", {63'd0, out_valid}, 64'd0);
        end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
        check({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
        check({tag, "_quotient"}, quotient, '0);
        check({tag, "_remainder"}, remainder, '0);
        check({tag, "_dbz"}, {63'd0, div_by_zero}, 64'd0);
    endtask

    task automatic start_op(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input logic s);
        int t = 0;
        @(negedge clk);
        dividend = a; divisor = b; is_signed = s; in_valid = 1'b1;
        while (!in_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) check("accept_timeout", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        dividend  = {$urandom, $urandom};
        divisor   = {$urandom, $urandom};
        is_signed = 1'($urandom);
    endtask

    task automatic finish_op(input int hold, output logic [XLEN-1:0] q, output logic [XLEN-1:0] r,
                             output logic dbz);
        int t = 0;
        if (hold > 0) out_ready = 1'b0;
        while (!out_valid && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!out_valid) check("done_timeout", {63'd0, out_valid}, 64'd1);
        q = quotient; r = remainder; dbz = div_by_zero;
        repeat (hold) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    function automatic logic [XLEN-1:0] rnd_val();
        logic [XLEN-1:0] v;
        case ($urandom_range(0, 7))
            0:       v = '0;
            1:       v = 64'd1;
            2:       v = '1;
            3:       v = MOST_NEG;
            4:       v = 64'($urandom_range(0, 20));
            5:       v = -64'($urandom_range(1, 20));
            6:       v = {$urandom, $urandom} >> $urandom_range(0, 63);
            default: v = {$urandom, $urandom};
        endcase
        return v;
    endfunction

    initial begin
        logic [XLEN-1:0] q, r;
        logic            d;
        exp_t            e;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        dividend = '0; divisor = '0; is_signed = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b0;

        e = ref_div(64'd100, 64'd7, 1'b0);
        check("model_100_7_q", e.q, 64'd14);
        check("model_100_7_r", e.r, 64'd2);
        e = ref_div(-64'd7, 64'd2, 1'b1);
        check("model_m7_2_q", e.q, SIGNED_MODE ? -64'd3 : 64'h7FFF_FFFF_FFFF_FFFC);

        start_op(64'd100, 64'd7, 1'b0);
        finish_op(0, q, r, d);
        check("u100_7_q", q, 64'd14);
        check("u100_7_r", r, 64'd2);
        check("u100_7_dbz", {63'd0, d}, 64'd0);

        start_op(64'h1234, 64'd0, 1'b0);
        finish_op(0, q, r, d);
        check("dz_q", q, '1);
        check("dz_r", r, 64'h1234);
        check("dz_dbz", {63'd0, d}, 64'd1);

        start_op(-64'd7, 64'd2, 1'b1);
        finish_op(0, q, r, d);
        check("s_m7_2_q", q, SIGNED_MODE ? -64'd3 : 64'h7FFF_FFFF_FFFF_FFFC);
        check("s_m7_2_r", r, SIGNED_MODE ? -64'd1 : 64'd1);

        start_op(64'd7, -64'd2, 1'b1);
        finish_op(0, q, r, d);
        check("s_7_m2_q", q, SIGNED_MODE ? -64'd3 : 64'd0);
        check("s_7_m2_r", r, SIGNED_MODE ? 64'd1 : 64'd7);

        start_op(MOST_NEG, '1, 1'b1);
        finish_op(0, q, r, d);
        check("ovf_q", q, SIGNED_MODE ? MOST_NEG : 64'd0);
        check("ovf_r", r, SIGNED_MODE ? 64'd0 : MOST_NEG);

        // Backpressure: hold DONE with a second request pending.
        start_op(64'd100, 64'd7, 1'b0);
        while (!out_valid && cyc < 100000) @(negedge clk);
        dividend = 64'd9; divisor = 64'd3; is_signed = 1'b0; in_valid = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check("bp_out_valid", {63'd0, out_valid}, 64'd1);
            check("bp_in_ready", {63'd0, in_ready}, 64'd0);
            check("bp_quotient", quotient, 64'd14);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_release_idle", {63'd0, in_ready}, 64'd1);
        check("bp_release_valid", {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        check("bp_second_accepted", {63'd0, in_ready}, 64'd0);
        in_valid = 1'b0;
        finish_op(0, q, r, d);
        check("bp_9_3_q", q, 64'd3);

        // Reset in the middle of CALC.
        start_op(64'd1234567, 64'd89, 1'b0);
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_vals("midrst");
        rst = 1'b0;
        start_op(64'd9, 64'd3, 1'b0);
        finish_op(0, q, r, d);
        check("post_rst_q", q, 64'd3);
        check("post_rst_r", r, 64'd0);

        for (int i = 0; i < 500 && n_errors < 20; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            start_op(rnd_val(), rnd_val(), 1'($urandom));
            finish_op($urandom_range(0, 3), q, r, d);
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
